// File: rtl/e0_keystream_gen.sv
// Bluetooth E0 keystream generator: OUT_W unrolled steps per clock, load handshake,
// optional warm-up discard and a valid/ready output register.
//
// state    | meaning
// IDLE     | waiting for the first initial state
// LOAD     | initial state captured, warm-up counter armed
// WARMUP   | stepping the core and discarding keystream bits
// RUN      | producing keystream words under backpressure
module e0_keystream_gen #(
  parameter int OUT_W  = 1,
  parameter int WARMUP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [127:0]     load_lfsr,
  input  logic [3:0]       load_c,
  output logic [OUT_W-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy
);

  localparam int CW = 11;
  localparam logic [CW-1:0] WARM_CYC = CW'(WARMUP / OUT_W);

  if (OUT_W < 1 || OUT_W > 8) begin : g_bad_out_w
    $error("e0_keystream_gen: OUT_W must be in 1..8");
  end
  if (WARMUP < 0 || WARMUP > 1024 || (WARMUP % OUT_W) != 0) begin : g_bad_warmup
    $error("e0_keystream_gen: WARMUP must be 0..1024 and a multiple of OUT_W");
  end

  // Field order matches {load_lfsr, load_c}, so a load is a plain vector copy.
  typedef struct packed {
    logic [38:0] r4;
    logic [32:0] r3;
    logic [30:0] r2;
    logic [24:0] r1;
    logic [1:0]  cp;
    logic [1:0]  c;
  } e0_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WARMUP, S_RUN} state_t;

  function automatic logic e0_z(input e0_t s);
    return s.r1[24] ^ s.r2[30] ^ s.r3[32] ^ s.r4[38] ^ s.c[0];
  endfunction

  function automatic e0_t e0_next(input e0_t s);
    e0_t        n;
    logic [2:0] y;
    logic [1:0] carry;
    y     = {2'b00, s.r1[24]} + {2'b00, s.r2[30]} + {2'b00, s.r3[32]} + {2'b00, s.r4[38]};
    carry = 2'((y + {1'b0, s.c}) >> 1);
    n.c   = carry ^ s.c ^ {s.cp[0], s.cp[1] ^ s.cp[0]};
    n.cp  = s.c;
    n.r1  = {s.r1[23:0], s.r1[24] ^ s.r1[19] ^ s.r1[11] ^ s.r1[7]};
    n.r2  = {s.r2[29:0], s.r2[30] ^ s.r2[23] ^ s.r2[15] ^ s.r2[11]};
    n.r3  = {s.r3[31:0], s.r3[32] ^ s.r3[27] ^ s.r3[23] ^ s.r3[3]};
    n.r4  = {s.r4[37:0], s.r4[38] ^ s.r4[35] ^ s.r4[27] ^ s.r4[3]};
    return n;
  endfunction

  state_t           state, state_nx;
  e0_t              st, adv, load_st;
  logic [OUT_W-1:0] word;
  logic [CW-1:0]    cnt;
  logic             rdy_en;
  logic             load_hs;
  logic             advance;

  assign load_st    = {load_lfsr, load_c};
  // rdy_en keeps load_ready low until the first clock after reset release.
  assign load_ready = rdy_en && (state == S_IDLE || state == S_RUN);
  assign load_hs    = load_valid && load_ready;
  assign busy       = (state == S_LOAD) || (state == S_WARMUP);
  assign advance    = (state == S_RUN) && (!ks_valid || ks_ready);

  always_comb begin
    word = '0;
    adv  = st;
    for (int k = 0; k < OUT_W; k++) begin
      word[k] = e0_z(adv);
      adv     = e0_next(adv);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_RUN: if (load_hs) state_nx = S_LOAD;
      S_LOAD:        state_nx = (WARMUP > 0) ? S_WARMUP : S_RUN;
      S_WARMUP:      if (cnt <= CW'(1)) state_nx = S_RUN;
      default:       state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      st       <= '0;
      cnt      <= '0;
      ks_data  <= '0;
      ks_valid <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      state  <= state_nx;
      // A load abandons any stream in flight, including a held output word.
      if (load_hs) begin
        st       <= load_st;
        cnt      <= WARM_CYC;
        ks_valid <= 1'b0;
      end else if (state == S_WARMUP) begin
        st  <= adv;
        cnt <= cnt - CW'(1);
      end else if (advance) begin
        st       <= adv;
        ks_data  <= word;
        ks_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_e0_keystream_gen.sv
// Directed bench for e0_keystream_gen: hand-computed first words, bit-serial reference
// model for longer streams, warm-up, backpressure, reload and async reset.
module tb_e0_keystream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] ld_lfsr;
  logic [3:0]   ld_c;

  logic lv_a, lr_a, kv_a, rdy_a, busy_a;
  logic [3:0] kd_a;
  logic lv_b, lr_b, kv_b, rdy_b, busy_b;
  logic [0:0] kd_b;
  logic lv_c, lr_c, kv_c, rdy_c, busy_c;
  logic [7:0] kd_c;
  logic lv_d, lr_d, kv_d, rdy_d, busy_d;
  logic [7:0] kd_d;

  e0_keystream_gen #(.OUT_W(4), .WARMUP(0)) dut_a (
    .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(lr_a), .load_lfsr(ld_lfsr),
    .load_c(ld_c), .ks_data(kd_a), .ks_valid(kv_a), .ks_ready(rdy_a), .busy(busy_a));
  e0_keystream_gen #(.OUT_W(1), .WARMUP(0)) dut_b (
    .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(lr_b), .load_lfsr(ld_lfsr),
    .load_c(ld_c), .ks_data(kd_b), .ks_valid(kv_b), .ks_ready(rdy_b), .busy(busy_b));
  e0_keystream_gen #(.OUT_W(8), .WARMUP(200)) dut_c (
    .clk(clk), .rst(rst), .load_valid(lv_c), .load_ready(lr_c), .load_lfsr(ld_lfsr),
    .load_c(ld_c), .ks_data(kd_c), .ks_valid(kv_c), .ks_ready(rdy_c), .busy(busy_c));
  e0_keystream_gen #(.OUT_W(8), .WARMUP(0)) dut_d (
    .clk(clk), .rst(rst), .load_valid(lv_d), .load_ready(lr_d), .load_lfsr(ld_lfsr),
    .load_c(ld_c), .ks_data(kd_d), .ks_valid(kv_d), .ks_ready(rdy_d), .busy(busy_d));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-serial reference model.
  logic [24:0] m_r1;
  logic [30:0] m_r2;
  logic [32:0] m_r3;
  logic [38:0] m_r4;
  logic [1:0]  m_c, m_cp;

  task automatic model_load(input logic [127:0] l, input logic [3:0] c);
    m_r4 = l[127:89];
    m_r3 = l[88:56];
    m_r2 = l[55:25];
    m_r1 = l[24:0];
    m_cp = c[3:2];
    m_c  = c[1:0];
  endtask

  task automatic model_step(output logic z);
    int         y;
    logic [1:0] s, t2, cn;
    logic       f1, f2, f3, f4;
    z  = m_r1[24] ^ m_r2[30] ^ m_r3[32] ^ m_r4[38] ^ m_c[0];
    y  = int'(m_r1[24]) + int'(m_r2[30]) + int'(m_r3[32]) + int'(m_r4[38]);
    s  = 2'((y + int'(m_c)) / 2);
    t2 = {m_cp[0], m_cp[1] ^ m_cp[0]};
    cn = s ^ m_c ^ t2;
    m_cp = m_c;
    m_c  = cn;
    f1 = m_r1[24] ^ m_r1[19] ^ m_r1[11] ^ m_r1[7];
    f2 = m_r2[30] ^ m_r2[23] ^ m_r2[15] ^ m_r2[11];
    f3 = m_r3[32] ^ m_r3[27] ^ m_r3[23] ^ m_r3[3];
    f4 = m_r4[38] ^ m_r4[35] ^ m_r4[27] ^ m_r4[3];
    m_r1 = {m_r1[23:0], f1};
    m_r2 = {m_r2[29:0], f2};
    m_r3 = {m_r3[31:0], f3};
    m_r4 = {m_r4[37:0], f4};
  endtask

  task automatic model_word4(output logic [3:0] w);
    logic z;
    for (int k = 0; k < 4; k++) begin
      model_step(z);
      w[k] = z;
    end
  endtask

  // Loads dut_a; returns negedges from the handshake edge to the first valid word.
  task automatic load_a(input logic [127:0] l, input logic [3:0] c, output int lat);
    int n;
    @(negedge clk);
    ld_lfsr = l;
    ld_c    = c;
    lv_a    = 1'b1;
    rdy_a   = 1'b0;
    n = 0;
    while (!lr_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("load_ready_a", lr_a, 1);
    @(posedge clk);
    #1;
    lv_a  = 1'b0;
    rdy_a = 1'b1;
    @(negedge clk);
    chk("valid_drop_a", kv_a, 0);
    lat = 0;
    while (!kv_a && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [127:0] lfsr;
    logic [3:0]   c;
    logic [3:0]   w0;
  } vec_t;

  vec_t vecs[8];
  logic expb[1280];
  logic gotb[1024];
  logic gotd[1024];
  logic [7:0] gotc[2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, nd, nc, lat_b, lat_c, lat_d, mis_b, mis_d;
    logic [3:0] e, held;
    logic [7:0] e8;
    logic pending;
    logic [127:0] seq_s;
    logic z;

    vecs[0] = '{lfsr: 128'd1 << 24, c: 4'b0000, w0: 4'b0001};
    vecs[1] = '{lfsr: 128'd0,       c: 4'b0001, w0: 4'b0011};
    vecs[2] = '{lfsr: 128'd0,       c: 4'b0010, w0: 4'b0110};
    vecs[3] = '{lfsr: 128'd1 << 127, c: 4'b0000, w0: 4'b0001};
    vecs[4] = '{lfsr: (128'd1 << 24) | (128'd1 << 55), c: 4'b0000, w0: 4'b0110};
    vecs[5] = '{lfsr: (128'd1 << 24) | (128'd1 << 55) | (128'd1 << 88) | (128'd1 << 127),
                c: 4'b0000, w0: 4'b1100};
    vecs[6] = '{lfsr: 128'd0,       c: 4'b0000, w0: 4'b0000};
    vecs[7] = '{lfsr: 128'd0,       c: 4'b0100, w0: 4'b1010};

    rst = 1'b0;
    ld_lfsr = '0;
    ld_c = '0;
    {lv_a, lv_b, lv_c, lv_d} = '0;
    {rdy_a, rdy_b, rdy_c, rdy_d} = '0;

    #12;
    chk("reset_load_ready", lr_a, 0);
    chk("reset_ks_valid", kv_a, 0);
    chk("reset_ks_data", kd_a, 0);
    chk("reset_busy", busy_a, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("load_ready_before_clk", lr_a, 0);
    @(negedge clk);
    chk("load_ready_after_clk", lr_a, 1);

    for (int v = 0; v < 8; v++) begin
      load_a(vecs[v].lfsr, vecs[v].c, lat);
      chk($sformatf("vec%0d_latency", v), lat, 2);
      chk($sformatf("vec%0d_word0", v), kd_a, vecs[v].w0);
      model_load(vecs[v].lfsr, vecs[v].c);
      model_word4(e);
      for (int j = 1; j < 4; j++) begin
        @(negedge clk);
        model_word4(e);
        chk($sformatf("vec%0d_word%0d", v, j), {kv_a, kd_a}, {1'b1, e});
      end
    end

    // Random backpressure against the model.
    seq_s = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    load_a(seq_s, 4'b1011, lat);
    chk("bp_latency", lat, 2);
    model_load(seq_s, 4'b1011);
    pending = 1'b0;
    held = '0;
    for (int i = 0; i < 200; i++) begin
      if (!pending) begin
        model_word4(e);
        chk("bp_word", {kv_a, kd_a}, {1'b1, e});
        held = kd_a;
      end else begin
        chk("bp_stable", {kv_a, kd_a}, {1'b1, held});
      end
      rdy_a = 1'($urandom_range(0, 1));
      pending = kv_a && !rdy_a;
      @(negedge clk);
    end

    // Reload while the consumer stalls a valid word.
    rdy_a = 1'b0;
    @(negedge clk);
    chk("stall_valid", kv_a, 1);
    load_a(vecs[5].lfsr, vecs[5].c, lat);
    chk("reload_latency", lat, 2);
    chk("reload_word0", kd_a, vecs[5].w0);
    model_load(vecs[5].lfsr, vecs[5].c);
    model_word4(e);
    @(negedge clk);
    model_word4(e);
    chk("reload_word1", {kv_a, kd_a}, {1'b1, e});

    // OUT_W=1, OUT_W=8 and OUT_W=8/WARMUP=200 loaded together with one state.
    seq_s = 128'hdead_beef_0bad_f00d_1357_9bdf_2468_ace0;
    model_load(seq_s, 4'b0110);
    for (int i = 0; i < 1280; i++) begin
      model_step(z);
      expb[i] = z;
    end
    @(negedge clk);
    ld_lfsr = seq_s;
    ld_c = 4'b0110;
    {lv_b, lv_c, lv_d} = 3'b111;
    {rdy_b, rdy_c, rdy_d} = 3'b111;
    chk("load_ready_bcd", {lr_b, lr_c, lr_d}, 3'b111);
    @(posedge clk);
    #1;
    {lv_b, lv_c, lv_d} = 3'b000;
    nb = 0; nd = 0; nc = 0;
    lat_b = -1; lat_c = -1; lat_d = -1;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(negedge clk);
      if (kv_b && nb < 1024) begin
        if (nb == 0) lat_b = cyc;
        gotb[nb] = kd_b[0];
        nb++;
      end
      if (kv_d && nd < 128) begin
        if (nd == 0) lat_d = cyc;
        for (int k = 0; k < 8; k++) gotd[nd*8+k] = kd_d[k];
        nd++;
      end
      if (kv_c && nc < 2) begin
        if (nc == 0) lat_c = cyc;
        gotc[nc] = kd_c;
        nc++;
      end
    end
    chk("w1_bit_count", nb, 1024);
    chk("w8_word_count", nd, 128);
    chk("warm_word_count", nc, 2);
    chk("w1_latency", lat_b, 2);
    chk("w8_latency", lat_d, 2);
    chk("warm_latency", lat_c, 27);
    mis_b = 0;
    mis_d = 0;
    for (int i = 0; i < 1024; i++) begin
      if (gotb[i] !== expb[i]) mis_b++;
      if (gotd[i] !== expb[i]) mis_d++;
    end
    chk("w1_stream_mismatches", mis_b, 0);
    chk("w8_stream_mismatches", mis_d, 0);
    for (int k = 0; k < 8; k++) e8[k] = expb[200+k];
    chk("warm_word0", gotc[0], e8);
    for (int k = 0; k < 8; k++) e8[k] = expb[208+k];
    chk("warm_word1", gotc[1], e8);

    // Asynchronous reset mid-warm-up (c) and mid-RUN (a).
    @(negedge clk);
    lv_c = 1'b1;
    @(posedge clk);
    #1;
    lv_c = 1'b0;
    repeat (5) @(negedge clk);
    chk("warm_busy", busy_c, 1);
    chk("run_valid_before_rst", kv_a, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_valid_a", kv_a, 0);
    chk("rst_data_a", kd_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_busy_c", busy_c, 0);
    chk("rst_valid_c", kv_c, 0);
    chk("rst_load_ready_a", lr_a, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_load_ready_early", lr_a, 0);
    @(negedge clk);
    chk("rel_load_ready", lr_a, 1);
    chk("rel_busy_c", busy_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e0_keystream_gen.md
# e0_keystream_gen

Parametrised Bluetooth E0 keystream generator, the next generation of the single-bit E0WithSRL core. It produces OUT_W keystream bits per clock, with a load handshake for the LFSR/combiner initial state and an optional hardware warm-up that discards a configured number of bits. Keystream output uses valid/ready backpressure. It sits between the key-setup logic (producer of the 132-bit initial state) and the payload XOR stage (keystream consumer).

## Interface

- OUT_W, 1: keystream bits produced per cycle (1..8); the E0 step is unrolled OUT_W times.
- WARMUP, 0: keystream bits discarded after each load (0..1024). Must be a multiple of OUT_W; elaboration error otherwise.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  initial state offered.
- load_ready  out  1  load accepted when load_valid && load_ready.
- load_lfsr  in  128  {R4[38:0], R3[32:0], R2[30:0], R1[24:0]}, MSBs first.
- load_c  in  4  {c_-1[1:0], c_0[1:0]}.
- ks_data  out  OUT_W  keystream; ks_data[0] is the earliest bit.
- ks_valid  out  1  ks_data holds a valid word.
- ks_ready  in  1  consumer accepts the word when ks_valid && ks_ready.
- busy  out  1  high in LOAD or WARMUP.

## Operation

- LFSR polynomials:
  - R1: x^25+x^20+x^12+x^8+1
  - R2: x^31+x^24+x^16+x^12+1
  - R3: x^33+x^28+x^24+x^4+1
  - R4: x^39+x^36+x^28+x^4+1
- LFSR step:
  - Output bit x_i is the top stage (R1[24], R2[30], R3[32], R4[38]).
  - Each step shifts up one stage. Stage 0 receives the XOR of the stages for exponents L, and the other nonzero terms, taken as stage index exponent−1.
  - R1 example: feedback = R1[24]^R1[19]^R1[11]^R1[7].
- Combiner per step:
  - y = x1+x2+x3+x4 (3-bit unsigned).
  - z = x1^x2^x3^x4^c_t[0].
  - s = (y + c_t) >> 1 (2 bits).
  - c_t+1 = s ^ c_t ^ T2(c_t-1), where T2({a,b}) = {b, a^b}.
  - c_t-1 <= c_t.
- Bit order: step k within a cycle (k = 0..OUT_W−1) drives ks_data[k].
- FSM states are IDLE, LOAD, WARMUP and RUN.
  - IDLE: load_ready=1, ks_valid=0.
  - LOAD: one cycle. Registers are written from load_lfsr/load_c, the warm-up counter is set to WARMUP/OUT_W, and ks_valid is cleared. Next state is WARMUP if WARMUP>0, else RUN.
  - WARMUP: advances OUT_W steps per cycle and discards z. The counter decrements; when it reaches 0 the FSM goes to RUN. load_ready=0.
  - RUN: ks_data/ks_valid form an output register.
    - When !ks_valid or ks_ready, the core advances OUT_W steps and loads the new word with ks_valid=1.
    - When ks_valid && !ks_ready, the core and the output are frozen; ks_data is stable.
    - load_ready=1.
- A handshake in RUN (or IDLE) goes to LOAD. It abandons the current stream; ks_valid drops the cycle after the handshake, and any unconsumed word is discarded.
- All-zero LFSR state is legal and is not detected.

## Timing

- Reset values:
  - load_ready=0, ks_valid=0, ks_data=0, busy=0.
  - All LFSRs and c registers are 0; state is IDLE.
  - load_ready rises on the first clock after rst deasserts.
- Load handshake at edge N: LOAD during cycle N+1.
- With WARMUP=0, the first ks_valid=1 is at edge N+2 and carries bits z0..z(OUT_W−1) of the loaded state.
- With WARMUP=W, the first valid word appears at edge N+2+W/OUT_W and carries z_W onward.
- Throughput is one word per cycle while ks_ready=1.
- Reset asserted mid-warm-up or mid-RUN clears everything immediately (async). No partial word survives.
- load_valid held with ks_ready=0 in RUN: the load wins and the held word is dropped.

## Test plan

- Reset behaviour: rst low mid-RUN with ks_valid=1 -> ks_valid=0 and busy=0 asynchronously; load_ready=1 one clock after release.
- OUT_W=4, WARMUP=0, load_lfsr=R1 stage 24 only (others 0), load_c=0 -> first word ks_data=4'b0001, ks_valid at handshake+2.
- OUT_W=4, WARMUP=0, all LFSR bits 0, load_c=4'b0001 -> first word ks_data=4'b0011 (z=1,1,0,0); second word matches the bit-serial model.
- Equivalence: random state, OUT_W=1 vs OUT_W=8 instances -> the concatenated bitstreams are identical for 1024 bits. WARMUP=200 with OUT_W=8 -> the first word equals bits 200..207 of the OUT_W=1 stream.
- Backpressure: ks_ready random 50% -> no word is lost or duplicated against the model, and ks_data is stable while stalled.
- Reload during RUN with ks_ready=0 -> ks_valid=0 next cycle; the new stream starts per the load latency with the new state's bits.
